// File: rtl/seg7_scan_ctrl_if.sv
// ============================================================================
// Module   : seg7_scan_ctrl_if
// Brief    : Host-side load bus and board-side pin bundle for seg7_scan_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface seg7_scan_ctrl_if #(
    parameter int NDIG     = 8,
    parameter int PWM_BITS = 4
);
    logic [4*NDIG-1:0]   digit;
    logic [NDIG-1:0]     dp;
    logic [NDIG-1:0]     blank;
    logic [NDIG-1:0]     blink;
    logic                lz_en;
    logic [PWM_BITS-1:0] bright;
    logic                load;

    logic [6:0]          a2g;
    logic                dp_n;
    logic [NDIG-1:0]     an;
    logic                frame_sync;

    modport master (
        output digit, dp, blank, blink, lz_en, bright, load,
        input  a2g, dp_n, an, frame_sync
    );

    modport slave (
        input  digit, dp, blank, blink, lz_en, bright, load,
        output a2g, dp_n, an, frame_sync
    );
endinterface

`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
// ============================================================================
// Module   : seg7_scan_ctrl
// Brief    : Multiplexed common-anode 7-segment scanner with double-buffered
//            digits, dp, blank/blink, leading-zero suppression and PWM dimming.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_scan_ctrl #(
    parameter int NDIG         = 8,
    parameter int REFRESH_DIV  = 131072,
    parameter int PWM_BITS     = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  wire              clk,
    input  wire              reset,
    seg7_scan_ctrl_if.slave  bus
);

    localparam int c_PS_W  = $clog2(REFRESH_DIV);
    localparam int c_SEL_W = $clog2(NDIG);
    localparam int c_FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // ------------------------------------------------------------------
    // Timebase: prescaler, digit select, frame and blink counters
    // ------------------------------------------------------------------
    logic [c_PS_W-1:0]  r_presc;
    logic [c_SEL_W-1:0] r_sel;
    logic [c_FC_W-1:0]  r_fcnt;
    logic               r_phase;
    logic               r_fs;
    logic               w_tick;
    logic               w_wrap;

    assign w_tick = (r_presc == c_PS_W'(REFRESH_DIV - 1));
    assign w_wrap = w_tick && (r_sel == c_SEL_W'(NDIG - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_sel   <= '0;
            r_fcnt  <= '0;
            r_phase <= 1'b0;
            r_fs    <= 1'b0;
        end else begin
            r_fs <= w_wrap;
            if (w_tick) begin
                r_presc <= '0;
                r_sel   <= w_wrap ? '0 : r_sel + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            if (w_wrap) begin
                if (r_fcnt == c_FC_W'(BLINK_FRAMES - 1)) begin
                    r_fcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Double buffer: pending set by load, promoted to active at frame wrap
    // ------------------------------------------------------------------
    logic [4*NDIG-1:0]   r_act_digit, r_pnd_digit;
    logic [NDIG-1:0]     r_act_dp,    r_pnd_dp;
    logic [NDIG-1:0]     r_act_blank, r_pnd_blank;
    logic [NDIG-1:0]     r_act_blink, r_pnd_blink;
    logic                r_act_lz,    r_pnd_lz;
    logic [PWM_BITS-1:0] r_act_bright, r_pnd_bright;
    logic                r_pflag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_act_digit  <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '1;
            r_act_blink  <= '0;
            r_act_lz     <= 1'b0;
            r_act_bright <= '0;
            r_pnd_digit  <= '0;
            r_pnd_dp     <= '0;
            r_pnd_blank  <= '1;
            r_pnd_blink  <= '0;
            r_pnd_lz     <= 1'b0;
            r_pnd_bright <= '0;
            r_pflag      <= 1'b0;
        end else begin
            if (bus.load) begin
                r_pnd_digit  <= bus.digit;
                r_pnd_dp     <= bus.dp;
                r_pnd_blank  <= bus.blank;
                r_pnd_blink  <= bus.blink;
                r_pnd_lz     <= bus.lz_en;
                r_pnd_bright <= bus.bright;
            end
            if (w_wrap) begin
                // A load landing on the wrap cycle bypasses pending so it is not lost a frame.
                if (bus.load) begin
                    r_act_digit  <= bus.digit;
                    r_act_dp     <= bus.dp;
                    r_act_blank  <= bus.blank;
                    r_act_blink  <= bus.blink;
                    r_act_lz     <= bus.lz_en;
                    r_act_bright <= bus.bright;
                end else if (r_pflag) begin
                    r_act_digit  <= r_pnd_digit;
                    r_act_dp     <= r_pnd_dp;
                    r_act_blank  <= r_pnd_blank;
                    r_act_blink  <= r_pnd_blink;
                    r_act_lz     <= r_pnd_lz;
                    r_act_bright <= r_pnd_bright;
                end
                r_pflag <= 1'b0;
            end else if (bus.load) begin
                r_pflag <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero suppression: w_zero_from[i] = nibbles i..NDIG-1 all zero
    // ------------------------------------------------------------------
    logic [NDIG:1]   w_zero_from;
    logic [NDIG-1:0] w_supp;

    assign w_zero_from[NDIG] = 1'b1;

    for (genvar gi = 1; gi < NDIG; gi++) begin : g_lz
        assign w_zero_from[gi] = w_zero_from[gi+1] & (r_act_digit[4*gi +: 4] == 4'h0);
    end

    assign w_supp = {w_zero_from[NDIG-1:1] & {(NDIG-1){r_act_lz}}, 1'b0};

    // ------------------------------------------------------------------
    // Current slot: segment decode, visibility and PWM gating
    // ------------------------------------------------------------------
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    logic [3:0]      w_nib;
    logic            w_hidden;
    logic            w_sup_sel;
    logic            w_dp_sel;
    logic            w_an_en;
    logic            w_pwm_on;
    logic [NDIG-1:0] w_an_next;
    logic [6:0]      w_a2g_next;
    logic            w_dpn_next;

    always_comb begin
        w_nib      = 4'(r_act_digit >> {r_sel, 2'b00});
        w_hidden   = r_act_blank[r_sel] | (r_phase & r_act_blink[r_sel]);
        w_sup_sel  = w_supp[r_sel];
        w_dp_sel   = r_act_dp[r_sel];
        // A suppressed digit still lights its anode when it must show its dp.
        w_an_en    = ~w_hidden & (~w_sup_sel | w_dp_sel);
        w_pwm_on   = (r_presc[PWM_BITS-1:0] <= r_act_bright);
        w_an_next  = '1;
        if (w_an_en && w_pwm_on) begin
            w_an_next[r_sel] = 1'b0;
        end
        w_a2g_next = (w_hidden || w_sup_sel) ? 7'h7F : seg_decode(w_nib);
        w_dpn_next = ~(w_an_en & w_dp_sel);
    end

    logic [NDIG-1:0] r_an;
    logic [6:0]      r_a2g;
    logic            r_dp_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an   <= '1;
            r_a2g  <= 7'h7F;
            r_dp_n <= 1'b1;
        end else begin
            r_an   <= w_an_next;
            r_a2g  <= w_a2g_next;
            r_dp_n <= w_dpn_next;
        end
    end

    assign bus.an         = r_an;
    assign bus.a2g        = r_a2g;
    assign bus.dp_n       = r_dp_n;
    assign bus.frame_sync = r_fs;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
// ============================================================================
// Module   : tb_seg7_scan_ctrl
// Brief    : Self-checking bench for seg7_scan_ctrl against a cycle-count model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seg7_scan_ctrl;

    localparam int NDIG         = 4;
    localparam int REFRESH_DIV  = 16;
    localparam int PWM_BITS     = 2;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME        = NDIG * REFRESH_DIV;

    localparam logic [6:0] SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic clk = 1'b0;
    logic reset = 1'b1;

    seg7_scan_ctrl_if #(.NDIG(NDIG), .PWM_BITS(PWM_BITS)) bus ();

    seg7_scan_ctrl #(
        .NDIG(NDIG), .REFRESH_DIV(REFRESH_DIV),
        .PWM_BITS(PWM_BITS), .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: time since reset release, number of frame wraps, and the two buffers.
    int          t;
    int          wraps;
    logic [15:0] a_dig, p_dig;
    logic [3:0]  a_dp, a_bl, a_bk, p_dp, p_bl, p_bk;
    logic        a_lz, p_lz, pflag;
    logic [1:0]  a_br, p_br;
    logic [12:0] exp_pins;

    task automatic model_reset();
        t = 0; wraps = 0; pflag = 1'b0;
        a_dig = '0; a_dp = '0; a_bl = 4'hF; a_bk = '0; a_lz = 1'b0; a_br = '0;
        p_dig = '0; p_dp = '0; p_bl = 4'hF; p_bk = '0; p_lz = 1'b0; p_br = '0;
    endtask

    function automatic logic [12:0] pins_of(int tt, int wr);
        int presc, sel, nib;
        logic phase, hidden, supp, lit;
        logic [3:0] an;
        logic [6:0] seg;
        presc  = tt % REFRESH_DIV;
        sel    = (tt / REFRESH_DIV) % NDIG;
        phase  = ((wr / BLINK_FRAMES) % 2) == 1;
        nib    = int'((a_dig >> (4 * sel)) & 16'hF);
        hidden = a_bl[sel] || (phase && a_bk[sel]);
        supp   = a_lz && sel > 0 && ((a_dig >> (4 * sel)) == 16'h0);
        seg    = (hidden || supp) ? 7'h7F : SEG[nib];
        lit    = !hidden && (!supp || a_dp[sel]);
        an     = 4'hF;
        if (lit && (presc % (1 << PWM_BITS)) <= int'(a_br)) an[sel] = 1'b0;
        return {an, seg, !(lit && a_dp[sel]),
                (presc == REFRESH_DIV - 1) && (sel == NDIG - 1)};
    endfunction

    // One clock: expected pins come from the pre-edge state, then the model advances.
    task automatic cycle();
        logic wrap;
        @(posedge clk);
        exp_pins = pins_of(t, wraps);
        wrap = (t % FRAME) == FRAME - 1;
        if (bus.load) begin
            if (wrap) begin
                a_dig = bus.digit; a_dp = bus.dp; a_bl = bus.blank; a_bk = bus.blink;
                a_lz = bus.lz_en; a_br = bus.bright; pflag = 1'b0;
            end else begin
                p_dig = bus.digit; p_dp = bus.dp; p_bl = bus.blank; p_bk = bus.blink;
                p_lz = bus.lz_en; p_br = bus.bright; pflag = 1'b1;
            end
        end else if (wrap && pflag) begin
            a_dig = p_dig; a_dp = p_dp; a_bl = p_bl; a_bk = p_bk;
            a_lz = p_lz; a_br = p_br; pflag = 1'b0;
        end
        if (wrap) wraps++;
        t++;
        #1;
    endtask

    task automatic set_inputs(logic [15:0] d, logic [3:0] dpv, logic [3:0] bl,
                              logic [3:0] bk, logic lz, logic [1:0] br);
        bus.digit = d; bus.dp = dpv; bus.blank = bl; bus.blink = bk;
        bus.lz_en = lz; bus.bright = br;
    endtask

    task automatic rand_inputs();
        logic [15:0] m;
        m = 16'hFFFF >> (4 * $urandom_range(0, 4));
        bus.digit  = 16'($urandom) & m;
        bus.dp     = 4'($urandom);
        bus.blank  = 4'($urandom & $urandom);
        bus.blink  = 4'($urandom & $urandom);
        bus.lz_en  = 1'($urandom);
        bus.bright = 2'($urandom);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checks++;
        if ({bus.an, bus.a2g, bus.dp_n, bus.frame_sync} !== 13'b1111_1111111_1_0) begin
            errors++;
            $display("FAIL reset_init got an=%b a2g=%b dp_n=%b fs=%b", bus.an, bus.a2g, bus.dp_n, bus.frame_sync);
        end
        reset = 1'b0;
        repeat (3 * FRAME + 5) begin
            cycle();
            checks++;
            if ({bus.an, bus.a2g, bus.dp_n, bus.frame_sync} !== exp_pins) begin
                errors++;
                $display("FAIL reset_idle t=%0d got %b want %b", t, {bus.an, bus.a2g, bus.dp_n, bus.frame_sync}, exp_pins);
            end
        end
    endtask

    // Load data, let it settle, then count anode-low cycles per digit over one frame.
    task automatic run_and_count(string name, int settle, int window, output int low [NDIG]);
        for (int i = 0; i < NDIG; i++) low[i] = 0;
        bus.load = 1'b1;
        cycle();
        bus.load = 1'b0;
        repeat (settle + window) begin
            cycle();
            checks++;
            if ({bus.an, bus.a2g, bus.dp_n, bus.frame_sync} !== exp_pins) begin
                errors++;
                $display("FAIL %s t=%0d got %b want %b", name, t, {bus.an, bus.a2g, bus.dp_n, bus.frame_sync}, exp_pins);
            end
            if (settle == 0) begin
                for (int i = 0; i < NDIG; i++) if (bus.an[i] == 1'b0) low[i]++;
            end else begin
                settle--;
            end
        end
    endtask

    task automatic test_display();
        int low [NDIG];
        set_inputs(16'h12AF, 4'h0, 4'h0, 4'h0, 1'b0, 2'd3);
        run_and_count("display", 2 * FRAME + 3, FRAME, low);
        for (int i = 0; i < NDIG; i++) begin
            checks++;
            if (low[i] != REFRESH_DIV) begin
                errors++;
                $display("FAIL display_duty digit%0d got %0d want %0d", i, low[i], REFRESH_DIV);
            end
        end
    endtask

    task automatic test_bright();
        int low [NDIG];
        set_inputs(16'h12AF, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0);
        run_and_count("bright", 2 * FRAME + 7, FRAME, low);
        for (int i = 0; i < NDIG; i++) begin
            checks++;
            if (low[i] != REFRESH_DIV / 4) begin
                errors++;
                $display("FAIL bright_duty digit%0d got %0d want %0d", i, low[i], REFRESH_DIV / 4);
            end
        end
    endtask

    task automatic test_lz();
        int low [NDIG];
        int want [NDIG];
        want = '{16, 16, 0, 16};
        set_inputs(16'h0050, 4'b1000, 4'h0, 4'h0, 1'b1, 2'd3);
        run_and_count("lz", 2 * FRAME + 11, FRAME, low);
        for (int i = 0; i < NDIG; i++) begin
            checks++;
            if (low[i] != want[i]) begin
                errors++;
                $display("FAIL lz_anode digit%0d got %0d want %0d", i, low[i], want[i]);
            end
        end
    endtask

    task automatic test_blink();
        int low [NDIG];
        set_inputs(16'h12AF, 4'h0, 4'h0, 4'b0001, 1'b0, 2'd3);
        run_and_count("blink", 2 * FRAME + 13, 2 * BLINK_FRAMES * FRAME, low);
        for (int i = 0; i < NDIG; i++) begin
            checks++;
            if (low[i] != ((i == 0) ? 2 * REFRESH_DIV : 4 * REFRESH_DIV)) begin
                errors++;
                $display("FAIL blink_duty digit%0d got %0d want %0d", i, low[i],
                         (i == 0) ? 2 * REFRESH_DIV : 4 * REFRESH_DIV);
            end
        end
    endtask

    task automatic test_back_to_back();
        int seen3;
        seen3 = 0;
        while ((t % FRAME) != 10) cycle();
        set_inputs(16'h3333, 4'h0, 4'h0, 4'h0, 1'b0, 2'd3);
        bus.load = 1'b1; cycle(); bus.load = 1'b0;
        repeat (5) cycle();
        set_inputs(16'h4444, 4'h0, 4'h0, 4'h0, 1'b0, 2'd3);
        bus.load = 1'b1; cycle(); bus.load = 1'b0;
        repeat (3 * FRAME) begin
            cycle();
            checks++;
            if ({bus.an, bus.a2g, bus.dp_n, bus.frame_sync} !== exp_pins) begin
                errors++;
                $display("FAIL back_to_back t=%0d got %b want %b", t, {bus.an, bus.a2g, bus.dp_n, bus.frame_sync}, exp_pins);
            end
            if (bus.a2g == 7'b0000110) seen3++;
        end
        checks++;
        if (seen3 != 0) begin
            errors++;
            $display("FAIL overwritten_load got %0d cycles of digit 3 want 0", seen3);
        end
    endtask

    task automatic test_load_at_wrap();
        while ((t % FRAME) != FRAME - 1) cycle();
        set_inputs(16'h5678, 4'h0, 4'h0, 4'h0, 1'b0, 2'd3);
        bus.load = 1'b1; cycle(); bus.load = 1'b0;
        cycle();
        checks++;
        if (bus.an !== 4'b1110 || bus.a2g !== 7'b0000000) begin
            errors++;
            $display("FAIL load_at_wrap got an=%b a2g=%b want an=1110 a2g=0000000", bus.an, bus.a2g);
        end
        repeat (FRAME) begin
            cycle();
            checks++;
            if ({bus.an, bus.a2g, bus.dp_n, bus.frame_sync} !== exp_pins) begin
                errors++;
                $display("FAIL load_at_wrap_frame t=%0d got %b want %b", t, {bus.an, bus.a2g, bus.dp_n, bus.frame_sync}, exp_pins);
            end
        end
    endtask

    task automatic test_async_reset();
        set_inputs(16'h9ABC, 4'hF, 4'h0, 4'h0, 1'b0, 2'd3);
        bus.load = 1'b1; cycle(); bus.load = 1'b0;
        repeat (21) cycle();
        reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({bus.an, bus.a2g, bus.dp_n, bus.frame_sync} !== 13'b1111_1111111_1_0) begin
            errors++;
            $display("FAIL async_reset got an=%b a2g=%b dp_n=%b fs=%b", bus.an, bus.a2g, bus.dp_n, bus.frame_sync);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2 * FRAME) begin
            cycle();
            checks++;
            if ({bus.an, bus.a2g, bus.dp_n, bus.frame_sync} !== exp_pins) begin
                errors++;
                $display("FAIL after_reset t=%0d got %b want %b", t, {bus.an, bus.a2g, bus.dp_n, bus.frame_sync}, exp_pins);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 60; k++) begin
            int idle;
            idle = $urandom_range(1, 90);
            rand_inputs();
            for (int c = 0; c < idle; c++) begin
                cycle();
                checks++;
                if ({bus.an, bus.a2g, bus.dp_n, bus.frame_sync} !== exp_pins) begin
                    errors++;
                    $display("FAIL random t=%0d got %b want %b", t, {bus.an, bus.a2g, bus.dp_n, bus.frame_sync}, exp_pins);
                end
            end
            rand_inputs();
            bus.load = 1'b1;
            cycle();
            bus.load = 1'b0;
            checks++;
            if ({bus.an, bus.a2g, bus.dp_n, bus.frame_sync} !== exp_pins) begin
                errors++;
                $display("FAIL random_load t=%0d got %b want %b", t, {bus.an, bus.a2g, bus.dp_n, bus.frame_sync}, exp_pins);
            end
            if ($urandom_range(0, 11) == 0) begin
                reset = 1'b1;
                #1;
                model_reset();
                checks++;
                if ({bus.an, bus.a2g, bus.dp_n, bus.frame_sync} !== 13'b1111_1111111_1_0) begin
                    errors++;
                    $display("FAIL random_reset got %b", {bus.an, bus.a2g, bus.dp_n, bus.frame_sync});
                end
                @(posedge clk);
                #1;
                reset = 1'b0;
            end
        end
    endtask

    initial begin
        set_inputs(16'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0);
        bus.load = 1'b0;
        test_reset();
        test_display();
        test_bright();
        test_lz();
        test_blink();
        test_back_to_back();
        test_load_at_wrap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
